// File: rtl/clb_cfg_pkg.sv
// Shared types and width helpers for the configuration-latch loader.
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int word_cnt_w(input int words);
    return clog2_min1(words);
  endfunction

  function automatic int blk_cnt_w(input int num_blocks);
    return clog2_min1(num_blocks);
  endfunction

endpackage

// File: rtl/config_word_deserializer.sv
// Shadow shift register that assembles one latch frame LSB-first from
// WORD_BITS-wide words, plus the in-frame word counter.
module config_word_deserializer
  import clb_cfg_pkg::*;
#(
  parameter int MEM_SIZE  = 16,
  parameter int WORD_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_shift_en,
  input  logic                 i_clear,
  input  logic [WORD_BITS-1:0] i_data,
  output logic [MEM_SIZE-1:0]  o_shadow,
  output logic                 o_last_word
);

  localparam int WORDS      = MEM_SIZE / WORD_BITS;
  localparam int WORD_CNT_W = word_cnt_w(WORDS);

  logic [MEM_SIZE-1:0]           r_shadow;
  logic [WORD_CNT_W-1:0]         r_word_cnt;
  logic [MEM_SIZE+WORD_BITS-1:0] w_cat;

  // Concatenate-then-slice keeps the shift legal even when MEM_SIZE == WORD_BITS.
  assign w_cat = {i_data, r_shadow};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else if (i_shift_en) begin
      r_shadow <= w_cat[MEM_SIZE+WORD_BITS-1:WORD_BITS];
    end else begin
      r_shadow <= r_shadow;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_word_cnt <= '0;
    end else if (i_shift_en) begin
      r_word_cnt <= o_last_word ? '0 : r_word_cnt + WORD_CNT_W'(1);
    end else begin
      r_word_cnt <= r_word_cnt;
    end
  end

  assign o_shadow    = r_shadow;
  assign o_last_word = (r_word_cnt == WORD_CNT_W'(WORDS - 1));

endmodule

// File: rtl/block_config_loader.sv
// Sequences a word stream into NUM_BLOCKS latch banks: deserialize a frame,
// then pulse the selected block's cen for one COMMIT cycle.
module block_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int MEM_SIZE   = 16,
  parameter int WORD_BITS  = 4,
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_valid,
  input  logic [WORD_BITS-1:0]  cfg_data,
  output logic                  cfg_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] cen,
  output logic                  busy,
  output logic                  done
);

  localparam int BLK_CNT_W = blk_cnt_w(NUM_BLOCKS);

  if (MEM_SIZE % WORD_BITS != 0) begin : g_bad_size
    $error("MEM_SIZE must be a multiple of WORD_BITS");
  end

  state_e                r_state, w_state_nxt;
  logic [BLK_CNT_W-1:0]  r_blk_cnt, w_blk_nxt;
  logic                  w_shift_en, w_clear, w_last_word, w_accept, w_last_blk;

  assign w_accept   = cfg_valid && (r_state == ST_LOAD);
  assign w_last_blk = (r_blk_cnt == BLK_CNT_W'(NUM_BLOCKS - 1));

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_blk_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_blk_cnt <= w_blk_nxt;
    end
  end

  // A start seen in LOAD restarts the pass and swallows any word on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk_cnt;
    w_shift_en  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_blk_nxt   = '0;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        if (start) begin
          w_blk_nxt = '0;
          w_clear   = 1'b1;
        end else if (w_accept) begin
          w_shift_en = 1'b1;
          if (w_last_word) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        if (w_last_blk) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LOAD;
          w_blk_nxt   = r_blk_cnt + BLK_CNT_W'(1);
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_blk_nxt   = '0;
        w_clear     = 1'b1;
      end
    endcase
  end

  config_word_deserializer #(
    .MEM_SIZE  (MEM_SIZE),
    .WORD_BITS (WORD_BITS)
  ) u_deser (
    .i_clk       (cclk),
    .i_rst       (rst),
    .i_shift_en  (w_shift_en),
    .i_clear     (w_clear),
    .i_data      (cfg_data),
    .o_shadow    (config_out),
    .o_last_word (w_last_word)
  );

  // Handshake and block enables depend on the state register only.
  always_comb begin
    cen = '0;
    if (r_state == ST_COMMIT) begin
      cen = NUM_BLOCKS'(1) << r_blk_cnt;
    end else begin
      cen = '0;
    end
  end

  assign cfg_ready = (r_state == ST_LOAD);
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_COMMIT);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_block_config_loader.sv
// Directed self-checking bench for block_config_loader with two 16-bit blocks.
`timescale 1ns/1ps
module tb_block_config_loader;

  logic        cclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_data = 4'h0;
  logic        cfg_ready;
  logic [15:0] config_out;
  logic [1:0]  cen;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [15:0] latch [2];
  logic [1:0]  log_cen [$];
  logic [15:0] log_dat [$];

  block_config_loader #(
    .MEM_SIZE   (16),
    .WORD_BITS  (4),
    .NUM_BLOCKS (2)
  ) dut (
    .cclk       (cclk),
    .rst        (rst),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .cen        (cen),
    .busy       (busy),
    .done       (done)
  );

  always #5 cclk = ~cclk;

  // Behavioural latch blocks: capture the shared bus at the edge ending COMMIT.
  always @(posedge cclk) begin
    if (cen[0]) latch[0] <= config_out;
    if (cen[1]) latch[1] <= config_out;
  end

  always @(negedge cclk) begin
    if (cen != 2'b00) begin
      log_cen.push_back(cen);
      log_dat.push_back(config_out);
    end
  end

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic send_words(input logic [31:0] words, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      cfg_valid = 1'b1;
      cfg_data  = words[4*i +: 4];
      while (!acc && t < 20) begin
        @(negedge cclk);
        acc = cfg_ready;
        tick();
        t++;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL send_word_timeout: word %0d not accepted in %0d cycles, required accept", i, t);
      end
      if (gapped) begin
        cfg_valid = 1'b0;
        tick();
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge cclk);
    total++;
    if ({cfg_ready, config_out, cen, busy, done} !== 21'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b cfg=%h cen=%b busy=%b done=%b, required all 0",
               cfg_ready, config_out, cen, busy, done);
    end
    tick();
    rst = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 4'h9;
    for (int c = 0; c < 3; c++) begin
      @(negedge cclk);
      total++;
      if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ready: cycle %0d ready=%b busy=%b, required 0/0", c, cfg_ready, busy);
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       exp_ready, exp_done, exp_busy;
    logic [1:0] exp_cen;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      cfg_data  = (c < 4) ? 4'(c + 1) : ((c >= 5 && c <= 8) ? 4'(c) : 4'h0);
      exp_ready = (c != 4) && (c != 9) && (c != 10);
      exp_cen   = (c == 4) ? 2'b01 : ((c == 9) ? 2'b10 : 2'b00);
      exp_done  = (c == 10);
      exp_busy  = (c < 10);
      @(negedge cclk);
      total++;
      if (cfg_ready !== exp_ready || cen !== exp_cen || done !== exp_done || busy !== exp_busy) begin
        bad++;
        $display("FAIL b2b_cycle%0d: ready=%b cen=%b done=%b busy=%b, required %b %b %b %b",
                 c, cfg_ready, cen, done, busy, exp_ready, exp_cen, exp_done, exp_busy);
      end
      if (c == 4 || c == 9) begin
        total++;
        if (config_out !== ((c == 4) ? 16'h4321 : 16'h8765)) begin
          bad++;
          $display("FAIL b2b_config_out%0d: got %h, required %h", c, config_out,
                   (c == 4) ? 16'h4321 : 16'h8765);
        end
      end
      tick();
    end
    cfg_valid = 1'b0;
    total++;
    if (latch[0] !== 16'h4321 || latch[1] !== 16'h8765) begin
      bad++;
      $display("FAIL b2b_latches: got %h %h, required 4321 8765", latch[0], latch[1]);
    end
  endtask

  task automatic test_gapped();
    log_cen.delete();
    log_dat.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_words(32'h8765_4321, 8, 1'b1);
    wait_done("gapped_done");
    total++;
    if (log_cen.size() != 2) begin
      bad++;
      $display("FAIL gapped_cen_count: got %0d pulses, required 2", log_cen.size());
    end else if (log_cen[0] !== 2'b01 || log_dat[0] !== 16'h4321 ||
                 log_cen[1] !== 2'b10 || log_dat[1] !== 16'h8765) begin
      bad++;
      $display("FAIL gapped_seq: got %b/%h %b/%h, required 01/4321 10/8765",
               log_cen[0], log_dat[0], log_cen[1], log_dat[1]);
    end
  endtask

  task automatic test_abort();
    log_cen.delete();
    log_dat.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_words(32'h0000_00BA, 2, 1'b0);
    start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data = 4'hC;
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    @(negedge cclk);
    total++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1 || log_cen.size() != 0) begin
      bad++;
      $display("FAIL abort_state: busy=%b ready=%b pulses=%0d, required 1 1 0",
               busy, cfg_ready, log_cen.size());
    end
    tick();
    send_words(32'h0000_4321, 4, 1'b0);
    tick();
    total++;
    if (log_cen.size() != 1) begin
      bad++;
      $display("FAIL abort_cen_count: got %0d pulses, required 1", log_cen.size());
    end else if (log_cen[0] !== 2'b01 || log_dat[0] !== 16'h4321) begin
      bad++;
      $display("FAIL abort_commit: got %b/%h, required 01/4321", log_cen[0], log_dat[0]);
    end
  endtask

  task automatic test_reset_in_commit();
    log_cen.delete();
    log_dat.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_words(32'h0000_5A3C, 4, 1'b0);
    @(negedge cclk);
    total++;
    if (cen !== 2'b01 || config_out !== 16'h5A3C) begin
      bad++;
      $display("FAIL rstc_commit: cen=%b cfg=%h, required 01/5a3c", cen, config_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge cclk);
    total++;
    if (cen !== 2'b00 || busy !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0 || config_out !== 16'h0) begin
      bad++;
      $display("FAIL rstc_after: cen=%b busy=%b ready=%b done=%b cfg=%h, required all 0",
               cen, busy, cfg_ready, done, config_out);
    end
    total++;
    if (latch[0] !== 16'h5A3C) begin
      bad++;
      $display("FAIL rstc_latch0: got %h, required 5a3c", latch[0]);
    end
    tick();
    log_cen.delete();
    log_dat.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_words(32'h8765_4321, 8, 1'b0);
    wait_done("rstc_rerun_done");
    total++;
    if (log_cen.size() != 2) begin
      bad++;
      $display("FAIL rstc_rerun_count: got %0d pulses, required 2", log_cen.size());
    end else if (log_cen[0] !== 2'b01 || log_dat[0] !== 16'h4321 ||
                 log_cen[1] !== 2'b10 || log_dat[1] !== 16'h8765) begin
      bad++;
      $display("FAIL rstc_rerun_seq: got %b/%h %b/%h, required 01/4321 10/8765",
               log_cen[0], log_dat[0], log_cen[1], log_dat[1]);
    end
  endtask

  task automatic test_rerun_from_done();
    @(negedge cclk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL rerun_pre_done: done=%b, required 1", done);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge cclk);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rerun_done_drop: done=%b busy=%b, required 0/1", done, busy);
    end
    tick();
    send_words(32'h89AB_CDEF, 8, 1'b0);
    wait_done("rerun_done");
    total++;
    if (latch[0] !== 16'hCDEF || latch[1] !== 16'h89AB) begin
      bad++;
      $display("FAIL rerun_latches: got %h %h, required cdef 89ab", latch[0], latch[1]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    latch[0] = 16'h0;
    latch[1] = 16'h0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_reset_in_commit();
    test_rerun_from_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
